// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - shared-ALU borrow bus between the multiply sequencer and the arbiter/ALU
interface mul_seq_if #(
  parameter int WORDSIZE  = 64,
  parameter int SHAMTSIZE = 6,
  parameter int ALUOPSIZE = 6
);
  logic                 req;
  logic                 gnt;
  logic [WORDSIZE-1:0]  a;
  logic [WORDSIZE-1:0]  b;
  logic [SHAMTSIZE-1:0] shamt;
  logic [ALUOPSIZE-1:0] op;
  logic [WORDSIZE-1:0]  res;

  modport master (output req, a, b, shamt, op, input gnt, res);
  modport slave  (input req, a, b, shamt, op, output gnt, res);
endinterface

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - shift-and-add MUL sequencer that borrows the shared ALU
// Only P/M/Q are added; every add and shift goes through the granted ALU.
module mul_seq #(
  parameter int WORDSIZE  = 64,
  parameter int SHAMTSIZE = 6,
  parameter int ALUOPSIZE = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORDSIZE-1:0] op_a,
  input  logic [WORDSIZE-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [WORDSIZE-1:0] result,
  mul_seq_if.master           alu
);

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_ORR = 2'b10;
  // {inv_a, inv_b, shift, shl, op}
  localparam logic [ALUOPSIZE-1:0] OP_ADD = ALUOPSIZE'({4'b0000, ALUOP_ADD});
  localparam logic [ALUOPSIZE-1:0] OP_SHL = ALUOPSIZE'({4'b0011, ALUOP_ORR});

  typedef enum logic [1:0] {IDLE, STEP, SHIFT, DONE} state_t;

  state_t state, state_nxt;
  logic [WORDSIZE-1:0] p, m, q;

  logic                 req;
  logic [WORDSIZE-1:0]  a_out, b_out;
  logic [SHAMTSIZE-1:0] shamt_out;
  logic [ALUOPSIZE-1:0] op_out;
  logic                 load_p, shift_m;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    a_out     = '0;
    b_out     = '0;
    shamt_out = '0;
    op_out    = '0;
    load_p    = 1'b0;
    shift_m   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = STEP;
      end
      STEP: begin
        if (q == '0) begin
          state_nxt = DONE;
        end else if (q[0]) begin
          req    = 1'b1;
          a_out  = p;
          b_out  = m;
          op_out = OP_ADD;
          if (alu.gnt) begin
            load_p    = 1'b1;
            state_nxt = SHIFT;
          end
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        req       = 1'b1;
        a_out     = m;
        shamt_out = SHAMTSIZE'(1);
        op_out    = OP_SHL;
        if (alu.gnt) begin
          shift_m   = 1'b1;
          state_nxt = STEP;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      p      <= '0;
      m      <= '0;
      q      <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        m <= op_a;
        q <= op_b;
        p <= '0;
      end
      if (load_p) p <= alu.res;
      if (shift_m) begin
        m <= alu.res;
        q <= q >> 1;
      end
      // Latch on the edge into DONE so result is already valid while done is high.
      if (state == STEP && q == '0) result <= p;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign alu.req   = req;
  assign alu.a     = a_out;
  assign alu.b     = b_out;
  assign alu.shamt = shamt_out;
  assign alu.op    = op_out;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - self-checking bench for mul_seq with an ALU model and a phase-level reference model
module tb_mul_seq;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n, start, alu_gnt;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] result;
  logic [W-1:0] alu_res, ua, ub;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_seq_if #(.WORDSIZE(W), .SHAMTSIZE(6), .ALUOPSIZE(6)) alu_bus ();

  mul_seq #(.WORDSIZE(W), .SHAMTSIZE(6), .ALUOPSIZE(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .alu(alu_bus.master)
  );

  // ALU: {inv_a, inv_b, shift, shl, op[1:0]} with op 00 add, 01 and, 10 orr, 11 xor
  always_comb begin
    ua = alu_bus.op[5] ? ~alu_bus.a : alu_bus.a;
    ub = alu_bus.op[4] ? ~alu_bus.b : alu_bus.b;
    if (alu_bus.op[3]) begin
      alu_res = alu_bus.op[2] ? (ua << alu_bus.shamt) : (ua >> alu_bus.shamt);
    end else begin
      case (alu_bus.op[1:0])
        2'b00:   alu_res = ua + ub;
        2'b01:   alu_res = ua & ub;
        2'b10:   alu_res = ua | ub;
        default: alu_res = ua ^ ub;
      endcase
    end
  end
  assign alu_bus.res = alu_res;
  assign alu_bus.gnt = alu_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a multiply is a list of phases derived from the operands.
  // kind 0 = cycle without ALU use, 1 = ALU request, 2 = done cycle.
  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  op;
    logic [5:0]  shamt;
  } phase_t;

  phase_t      ph_q[$];
  bit          m_en = 1'b0;
  logic [63:0] m_result = '0;
  logic [63:0] m_prod = '0;
  int          m_cyc, m_denied, m_k;

  function automatic int top_k(input logic [63:0] b);
    int k = 0;
    for (int i = 0; i < 64; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic build(input logic [63:0] a, input logic [63:0] b);
    phase_t ph;
    m_prod   = a * b;
    m_k      = top_k(b);
    m_cyc    = 0;
    m_denied = 0;
    for (int i = 0; i < m_k; i++) begin
      ph = '{kind: 0, a: '0, b: '0, op: '0, shamt: '0};
      if (b[i]) begin
        ph.kind = 1;
        ph.a    = a * (b & ((64'd1 << i) - 64'd1));
        ph.b    = a << i;
      end
      ph_q.push_back(ph);
      ph = '{kind: 1, a: a << i, b: '0, op: 6'b001110, shamt: 6'd1};
      ph_q.push_back(ph);
    end
    ph = '{kind: 0, a: '0, b: '0, op: '0, shamt: '0};
    ph_q.push_back(ph);
    ph.kind = 2;
    ph_q.push_back(ph);
  endtask

  always @(negedge clk) begin : model
    phase_t ph;
    bit     idle_now;
    idle_now = (ph_q.size() == 0);
    if (m_en) begin
      if (idle_now) begin
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_req", alu_bus.req, 1'b0);
        check("idle_alu", {alu_bus.a | alu_bus.b, alu_bus.op, alu_bus.shamt} == '0, 1'b1);
        check("idle_result", result, m_result);
      end else begin
        ph = ph_q[0];
        m_cyc++;
        check("busy", busy, 1'b1);
        check("done", done, ph.kind == 2);
        check("alu_req", alu_bus.req, ph.kind == 1);
        check("alu_a", alu_bus.a, ph.a);
        check("alu_b", alu_bus.b, ph.b);
        check("alu_op", alu_bus.op, ph.op);
        check("alu_shamt", alu_bus.shamt, ph.shamt);
        if (ph.kind == 2) begin
          check("done_result", result, m_prod);
          check("latency", m_cyc, 2 * m_k + 2 + m_denied);
          m_result = m_prod;
          void'(ph_q.pop_front());
        end else if (ph.kind == 0 || alu_gnt) begin
          void'(ph_q.pop_front());
        end else begin
          m_denied++;
        end
      end
    end
    if (!rst_n) begin
      ph_q.delete();
      m_result = '0;
      m_en     = 1'b1;
    end else if (m_en && idle_now && start) begin
      build(op_a, op_b);
    end
  end

  task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input bit alt,
                        output int cyc, output bit anyreq, output logic [15:0] pat,
                        output logic [63:0] res);
    bit got;
    @(posedge clk); #1;
    op_a = a; op_b = b; start = 1'b1; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = 64'hdead_beef; op_b = 64'h1234;
    cyc = 0; got = 1'b0; anyreq = 1'b0; pat = '0; res = '0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (alu_bus.req) anyreq = 1'b1;
      if (cyc <= 16) pat[cyc-1] = alu_bus.req;
      if (done) begin
        got = 1'b1;
        res = result;
      end else begin
        @(posedge clk); #1;
        if (alt) alu_gnt = ~alu_gnt;
        if (alt && cyc == 4) begin
          start = 1'b1; op_a = 64'd99; op_b = 64'd99;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!got) check("done_timeout", 1'b0, 1'b1);
  endtask

  int          cyc, ndone;
  bit          anyreq;
  logic [15:0] pat;
  logic [63:0] res;

  initial begin
    rst_n = 1'b0; start = 1'b1; op_a = 64'd5; op_b = 64'd5; alu_gnt = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 64'd0);
    check("rst_req", alu_bus.req, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);

    do_mul(64'd3, 64'd5, 1'b0, cyc, anyreq, pat, res);
    check("3x5_cycles", cyc, 8);
    check("3x5_result", res, 64'd15);
    check("3x5_req_pattern", pat[7:0], 8'h3B);
    repeat (3) @(negedge clk);
    check("3x5_hold", result, 64'd15);

    do_mul(64'h7, 64'd0, 1'b0, cyc, anyreq, pat, res);
    check("x0_cycles", cyc, 2);
    check("x0_result", res, 64'd0);
    check("x0_no_req", anyreq, 1'b0);

    do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, cyc, anyreq, pat, res);
    check("wrap_cycles", cyc, 6);
    check("wrap_result", res, 64'hFFFF_FFFF_FFFF_FFFE);

    do_mul(64'd1, 64'h8000_0000_0000_0000, 1'b0, cyc, anyreq, pat, res);
    check("msb_cycles", cyc, 130);
    check("msb_result", res, 64'h8000_0000_0000_0000);

    do_mul(64'd6, 64'd7, 1'b1, cyc, anyreq, pat, res);
    check("stall_cycles", cyc, 13);
    check("stall_result", res, 64'd42);
    alu_gnt = 1'b1;

    @(posedge clk); #1;
    op_a = 64'd3; op_b = 64'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, 64'd0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    do_mul(64'd4, 64'd4, 1'b0, cyc, anyreq, pat, res);
    check("after_abort_cycles", cyc, 8);
    check("after_abort_result", res, 64'd16);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
Multi-cycle sequencer that computes MUL (low WORDSIZE bits of a×b) by driving the shared ALU through shift-and-add steps. It sits beside the execute stage and borrows the ALU through a request/grant handshake with the pipeline arbiter. It adds no multiplier hardware; only the accumulator, multiplicand and multiplier registers are added. The low result is identical for signed and unsigned operands, so signedness is ignored.

Parameters:
WORDSIZE, 64, operand/result width (matches `WORDSIZE)
SHAMTSIZE, 6, ALU shift-amount width (matches `SHAMTSIZE)
ALUOPSIZE, 6, ALU opcode width (matches `ALUOPSIZE)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a multiply; sampled only in IDLE
op_a  in  WORDSIZE  multiplicand, captured with start
op_b  in  WORDSIZE  multiplier, captured with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, result valid
result  out  WORDSIZE  product, held until the next accepted start
alu_req  out  1  ALU wanted this cycle
alu_gnt  in  1  arbiter grant; ALU result consumed only when req&gnt
alu_a  out  WORDSIZE  ALU operand A
alu_b  out  WORDSIZE  ALU operand B
alu_shamt  out  SHAMTSIZE  ALU shift amount
alu_op  out  ALUOPSIZE  ALU opcode {inv_a, inv_b, shift, shl, op[1:0]}
alu_res  in  WORDSIZE  ALU result (combinational from alu_* outputs)

Behaviour:
- Clock/reset: one clock, clk; rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state=IDLE. busy=0, done=0, result=0, alu_req=0, alu_a=alu_b=0, alu_shamt=0, alu_op=0. Internal P, M and Q are cleared.
- Reset mid-operation aborts with no done pulse; the next start after reset works normally.
- Registers: P (accumulator), M (multiplicand), Q (multiplier), all WORDSIZE bits wide.
- States: IDLE, STEP, SHIFT, DONE.
- IDLE, start=1: load M=op_a, Q=op_b, P=0, then go to STEP.
- IDLE, start=0: hold.
- STEP, Q==0: go to DONE. No ALU request.
- STEP, Q[0]=1: alu_req=1, alu_a=P, alu_b=M, alu_op={0,0,0,0,`ALUOP_ADD}, alu_shamt=0.
  - If gnt: P<=alu_res, go to SHIFT.
  - Else hold STEP with outputs unchanged.
- STEP, Q[0]=0 (Q!=0): go to SHIFT with no request.
- SHIFT: alu_req=1, alu_a=M, alu_b=0, alu_op={0,0,1,1,`ALUOP_ORR} (left shift), alu_shamt=1.
  - If gnt: M<=alu_res, Q<=Q>>1 (logical), go to STEP.
  - Else hold.
- DONE: result<=P on entry; done=1 for exactly this cycle; busy=1; return to IDLE.
- alu_req=0 outside granted-use states. When alu_req=0, all alu_* outputs are 0.
- Arithmetic wraps modulo 2^WORDSIZE. ALU carry/overflow are ignored; there is no overflow indication.
- start while busy is ignored (not queued).
- start in the IDLE cycle that immediately follows DONE is accepted.
- Latency with gnt held at 1: let k = index of the highest set bit of op_b plus 1 (k=0 for op_b=0).
  - done is asserted 2k+2 cycles after the start edge.
  - Range is 2 to 130 cycles.
  - Each gnt=0 cycle during a request adds one cycle.
- Termination is guaranteed: Q reaches 0 after at most WORDSIZE shifts.

Test Plan:
- Reset → all outputs 0. Hold rst_n=0 with start=1 → stays IDLE, busy=0.
- op_a=3, op_b=5, gnt=1 → done at cycle 8 after start. result=15. alu_req pattern 1,1,0,1,1,1,0,0. result holds 15 afterwards.
- op_a=0x7, op_b=0 → done at cycle 2 with result=0, and alu_req is never asserted. Separately, op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=2 → result=0xFFFF_FFFF_FFFF_FFFE (wraps).
- op_b=0x8000_0000_0000_0000, op_a=1 → done at cycle 130, result=0x8000_0000_0000_0000.
- op_a=6, op_b=7, gnt deasserted on alternate cycles → alu_* stay stable while stalled, result=42, latency increases by exactly the number of denied request cycles. Also pulse start while busy → ignored.
- Assert rst_n=0 mid-operation (cycle 3 of 3×5) → IDLE next cycle, no done pulse. A new start with op_a=4, op_b=4 → result=16.
